ce_divider_capture_bank: RTL and testbench
==========================================

Name: ce_divider_capture_bank

Overview:
Parametrised, single-clock successor to the PLL fan-out capture test design. Instead of per-output clocks, one clock drives NUM_CH clock-enable dividers, each with a runtime divide ratio and phase offset. Each enable gates a DEPTH-stage capture chain fed from a shared serial input. A lock state machine mimics PLL LOCKED and suppresses captures until the dividers are stable after reset or reconfiguration.

Parameters:
NUM_CH, 3, number of divider/capture channels (1..16)
DIV_W, 4, width of each divide and phase field (2..8)
DEPTH, 2, capture stages per channel (1..8)
LOCK_CYCLES, 16, clocks from reset or cfg_load to locked assertion (>=1)

Ports:
clk  in  1  sole clock; all state on rising edge
cpu_reset_n  in  1  synchronous active-low reset
cfg_div  in  NUM_CH*DIV_W  per-channel divide ratio; channel i at [i*DIV_W +: DIV_W]
cfg_phase  in  NUM_CH*DIV_W  per-channel phase offset, same packing
cfg_load  in  1  one-cycle pulse; latches cfg_div and cfg_phase and restarts lock
data_in  in  1  shared serial capture input
data_out  out  NUM_CH  last chain stage of each channel
locked  out  1  high when dividers are stable and captures are enabled

Behaviour:
- Interface: one clock, clk. Reset cpu_reset_n is synchronous and active-low.
- Reset (cpu_reset_n=0 sampled):
  - latched div becomes 1 for all channels; latched phase becomes 0.
  - all divider counters, chain stages and data_out clear to 0.
  - locked clears to 0; FSM enters UNLOCKED with lock_cnt=0.
- Reset has priority over cfg_load in the same cycle.
- Config latch:
  - cfg_load=1 sampled: latch both vectors, clear every divider counter to 0, lock_cnt to 0, FSM to UNLOCKED.
  - Chain contents and data_out hold.
  - Latched div of 0 is treated as 1.
  - Latched phase >= effective div is clamped to div-1 at latch time.
- Divider, per channel:
  - cnt counts 0..div-1, then wraps to 0. It runs in both FSM states.
  - ce_raw=1 in cycles where cnt==phase. Period is div cycles.
  - All channels are phase-aligned: cnt=0 in the first cycle after reset or load.
- FSM:
  - UNLOCKED: lock_cnt increments each cycle. When lock_cnt==LOCK_CYCLES-1, next state is LOCKED.
  - So locked=1 exactly LOCK_CYCLES edges after the edge that sampled reset or load.
  - LOCKED: locked=1. cfg_load returns to UNLOCKED, dropping locked on the next edge.
  - cfg_load while UNLOCKED restarts lock_cnt from 0.
- Capture:
  - ce = ce_raw & locked.
  - On ce, channel chain shifts: stage0<=data_in, stage k<=stage k-1. data_out[i] is stage DEPTH-1.
  - Latency: data_in sampled at ce edge n appears on data_out after DEPTH ce events of that channel.
  - No shifting while ce=0; chain holds.
- Boundaries:
  - div=1: ce every cycle while locked; channel behaves as a plain DEPTH-stage shift register.
  - Maximum div is 2^DIV_W-1; the counter must not overflow at wrap.
  - A cfg_load in the same cycle as a ce: the capture happens (uses pre-load state); the counter then restarts.
- Implementation: all registers synchronous; no combinational path from data_in to data_out.

Optional Feature:
- Macro CE_OUT_EN.
- Defined: adds output ce_out[NUM_CH], equal to registered ce of each channel (one-cycle delayed pulse, reset 0), for scope and bench observation.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
1. Reset hold 3 cycles then release with data_in=1, no load -> data_out=0 and locked=0 for 16 edges; locked=1 on edge 16; thereafter every channel (div=1) shows 1 on data_out after 2 cycles.
2. Load div={6,3,12} (ch2,ch1,ch0), phase={5,0,11}, locked high -> ce pulses every 12/3/6 cycles. First ch0 ce 11 cycles after load (if locked), ch1 at offset 0 mod 3, ch2 at offset 5 mod 6. ce_out matches with CE_OUT_EN defined.
3. Toggle data_in per cycle with ch0 div=4, phase=0 -> data_out[0] reproduces the data_in value sampled 2 ce events (8 cycles) earlier; chain holds between ce.
4. cfg_load mid-LOCKED with div=0, phase=7 -> locked falls next edge; latched div=1, phase=0; relocks after 16 cycles; chain contents are preserved across the load.
5. cfg_load pulsed again at lock_cnt=10 -> locked stays 0 until 16 cycles after the second load; cpu_reset_n=0 together with cfg_load -> reset wins, latched div=1.
6. phase=9 with div=5 -> clamped to 4; ce when cnt==4, period 5.

Source files
------------

// File: rtl/ce_divider_capture_bank.sv
// ce_divider_capture_bank: one clock drives NUM_CH clock-enable dividers.
// Each divider has its own runtime divide ratio and phase offset. Each
// enable gates a DEPTH-stage capture chain fed from the shared data_in.
// A lock state machine plays the role of a PLL LOCKED signal. It holds
// captures off for LOCK_CYCLES clocks after reset or after cfg_load.
// Optional feature: define CE_OUT_EN to add ce_out, the registered
// per-channel enable.
module ce_divider_capture_bank #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 4,
    parameter int DEPTH       = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    cpu_reset_n,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
    input  logic                    cfg_load,
    input  logic                    data_in,
    output logic [NUM_CH-1:0]       data_out,
`ifdef CE_OUT_EN
    output logic [NUM_CH-1:0]       ce_out,
`endif
    output logic                    locked
);

    localparam int LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t       state_r;
    lock_state_t       state_nxt_s;
    logic [LCNT_W-1:0] lock_cnt_r;
    logic [LCNT_W-1:0] lock_cnt_nxt_s;
    logic              locked_r;
    logic              locked_nxt_s;

    logic [DIV_W-1:0]  div_r       [NUM_CH];
    logic [DIV_W-1:0]  phase_r     [NUM_CH];
    logic [DIV_W-1:0]  cnt_r       [NUM_CH];
    logic [DIV_W-1:0]  cnt_nxt_s   [NUM_CH];
    logic [DIV_W-1:0]  div_eff_s   [NUM_CH];
    logic [DIV_W-1:0]  phase_eff_s [NUM_CH];
    logic [DEPTH-1:0]  chain_r     [NUM_CH];
    logic [DEPTH-1:0]  chain_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] ce_s;

`ifdef CE_OUT_EN
    logic [NUM_CH-1:0] ce_out_r;
    assign ce_out = ce_out_r;
`endif

    assign locked = locked_r;

    // Divider compare/wrap, gated enable, chain shift value and sanitised config
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ce_s[i] = (cnt_r[i] == phase_r[i]) && locked_r;
            if (cnt_r[i] == (div_r[i] - DIV_W'(1))) begin
                cnt_nxt_s[i] = {DIV_W{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + DIV_W'(1);
            end
            chain_nxt_s[i] = chain_r[i];
            chain_nxt_s[i][0] = data_in;
            for (int k = 1; k < DEPTH; k++) begin
                chain_nxt_s[i][k] = chain_r[i][k-1];
            end
            if (cfg_div[i*DIV_W +: DIV_W] == {DIV_W{1'b0}}) begin
                div_eff_s[i] = DIV_W'(1);
            end else begin
                div_eff_s[i] = cfg_div[i*DIV_W +: DIV_W];
            end
            if (cfg_phase[i*DIV_W +: DIV_W] >= div_eff_s[i]) begin
                phase_eff_s[i] = div_eff_s[i] - DIV_W'(1);
            end else begin
                phase_eff_s[i] = cfg_phase[i*DIV_W +: DIV_W];
            end
        end
    end

    // Lock FSM next-state: count up while unlocked, cfg_load restarts
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (lock_cnt_r == LCNT_LAST) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r + LCNT_W'(1);
                end
            end
            ST_LOCKED: begin
                state_nxt_s = ST_LOCKED;
            end
            default: begin
                state_nxt_s    = ST_UNLOCKED;
                lock_cnt_nxt_s = {LCNT_W{1'b0}};
            end
        endcase
        if (cfg_load) begin
            state_nxt_s    = ST_UNLOCKED;
            lock_cnt_nxt_s = {LCNT_W{1'b0}};
        end else begin
            lock_cnt_nxt_s = lock_cnt_nxt_s;
        end
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
    end

    // Lock FSM state, counter and registered locked flag
    always_ff @(posedge clk) begin
        if (!cpu_reset_n) begin
            state_r    <= ST_UNLOCKED;
            lock_cnt_r <= {LCNT_W{1'b0}};
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            locked_r   <= locked_nxt_s;
        end
    end

    // Config latch, divider counters and capture chains
    always_ff @(posedge clk) begin
        if (!cpu_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_r[i]   <= DIV_W'(1);
                phase_r[i] <= {DIV_W{1'b0}};
                cnt_r[i]   <= {DIV_W{1'b0}};
                chain_r[i] <= {DEPTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // capture uses pre-load state even when a load lands on a ce
                if (ce_s[i]) begin
                    chain_r[i] <= chain_nxt_s[i];
                end
                if (cfg_load) begin
                    div_r[i]   <= div_eff_s[i];
                    phase_r[i] <= phase_eff_s[i];
                    cnt_r[i]   <= {DIV_W{1'b0}};
                end else begin
                    cnt_r[i]   <= cnt_nxt_s[i];
                end
            end
        end
    end

`ifdef CE_OUT_EN
    // Registered copy of each channel enable for observation
    always_ff @(posedge clk) begin
        if (!cpu_reset_n) begin
            ce_out_r <= {NUM_CH{1'b0}};
        end else begin
            ce_out_r <= ce_s;
        end
    end
`endif

    // Last chain stage of each channel drives data_out
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            data_out[i] = chain_r[i][DEPTH-1];
        end
    end

endmodule

// File: tb/tb_ce_divider_capture_bank.sv
// Scoreboard bench for ce_divider_capture_bank. The stimulus process
// advances a cycle-count reference model after each clock edge and queues
// the expected outputs. A monitor pops the queue and compares on every
// falling edge.
module tb_ce_divider_capture_bank;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 4;
    localparam int DEPTH       = 2;
    localparam int LOCK_CYCLES = 16;
    localparam int VW          = NUM_CH * DIV_W;

    logic              clk = 1'b0;
    logic              cpu_reset_n;
    logic [VW-1:0]     cfg_div;
    logic [VW-1:0]     cfg_phase;
    logic              cfg_load;
    logic              data_in;
    logic [NUM_CH-1:0] data_out;
    logic              locked;
`ifdef CE_OUT_EN
    logic [NUM_CH-1:0] ce_out;
`endif

    always #5 clk = ~clk;

    ce_divider_capture_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEPTH(DEPTH), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk),
        .cpu_reset_n(cpu_reset_n),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_load(cfg_load),
        .data_in(data_in),
        .data_out(data_out),
`ifdef CE_OUT_EN
        .ce_out(ce_out),
`endif
        .locked(locked)
    );

    typedef struct {
        logic [NUM_CH-1:0] dout;
        logic              lk;
        logic [NUM_CH-1:0] ce;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: edges since last reset/load, per-channel ratio/phase, chain bits
    int   t;
    int   mdiv [NUM_CH];
    int   mph  [NUM_CH];
    logic mch  [NUM_CH][DEPTH];

    function automatic logic [VW-1:0] pk3(input int c2, input int c1, input int c0);
        logic [DIV_W-1:0] a2, a1, a0;
        a2 = DIV_W'(c2);
        a1 = DIV_W'(c1);
        a0 = DIV_W'(c0);
        return {a2, a1, a0};
    endfunction

    task automatic model_edge(input logic rn, input logic ld, input logic [VW-1:0] dv,
                              input logic [VW-1:0] pv, input logic din, output exp_t e);
        logic [NUM_CH-1:0] ce;
        int d, p;
        ce = '0;
        if (!rn) begin
            t = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                mdiv[i] = 1;
                mph[i]  = 0;
                for (int k = 0; k < DEPTH; k++) mch[i][k] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ce[i] = (t >= LOCK_CYCLES) && ((t % mdiv[i]) == mph[i]);
                if (ce[i]) begin
                    for (int k = DEPTH - 1; k > 0; k--) mch[i][k] = mch[i][k-1];
                    mch[i][0] = din;
                end
            end
            if (ld) begin
                t = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    d = int'(dv[i*DIV_W +: DIV_W]);
                    p = int'(pv[i*DIV_W +: DIV_W]);
                    if (d == 0) d = 1;
                    if (p >= d) p = d - 1;
                    mdiv[i] = d;
                    mph[i]  = p;
                end
            end else begin
                t = t + 1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) e.dout[i] = mch[i][DEPTH-1];
        e.lk = (t >= LOCK_CYCLES);
        e.ce = ce;
    endtask

    task automatic step(input logic rn, input logic ld, input logic [VW-1:0] dv,
                        input logic [VW-1:0] pv, input logic din);
        exp_t e;
        cpu_reset_n = rn;
        cfg_load    = ld;
        cfg_div     = dv;
        cfg_phase   = pv;
        data_in     = din;
        @(posedge clk);
        #1;
        model_edge(rn, ld, dv, pv, din, e);
        q.push_back(e);
        cfg_load = 1'b0;
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (data_out !== e.dout) begin
                    errors++;
                    $display("FAIL data_out t=%0t got=%b exp=%b", $time, data_out, e.dout);
                end
                checks++;
                if (locked !== e.lk) begin
                    errors++;
                    $display("FAIL locked t=%0t got=%b exp=%b", $time, locked, e.lk);
                end
`ifdef CE_OUT_EN
                checks++;
                if (ce_out !== e.ce) begin
                    errors++;
                    $display("FAIL ce_out t=%0t got=%b exp=%b", $time, ce_out, e.ce);
                end
`endif
            end
        end
    end

    // Stimulus
    initial begin
        logic tog;
        cpu_reset_n = 1'b0;
        cfg_load    = 1'b0;
        cfg_div     = '0;
        cfg_phase   = '0;
        data_in     = 1'b1;

        // 1: reset, then lock with default div=1, data_in=1
        repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (24) step(1'b1, 1'b0, '0, '0, 1'b1);

        // 2: div {6,3,12}, phase {5,0,11}
        step(1'b1, 1'b1, pk3(6, 3, 12), pk3(5, 0, 11), 1'b0);
        run_rand(70);

        // 3: ch0 div 4 phase 0, toggling data
        step(1'b1, 1'b1, pk3(6, 3, 4), pk3(5, 0, 0), 1'b0);
        tog = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tog = ~tog;
            step(1'b1, 1'b0, '0, '0, tog);
        end

        // 4: load div=0 phase=7 while locked
        step(1'b1, 1'b1, pk3(0, 0, 0), pk3(7, 7, 7), 1'b1);
        run_rand(30);

        // 5: load (lands on a div=1 ce), reload at lock_cnt=10, then reset with load
        step(1'b1, 1'b1, pk3(2, 3, 4), pk3(1, 2, 3), 1'b1);
        run_rand(10);
        step(1'b1, 1'b1, pk3(2, 3, 4), pk3(1, 2, 3), 1'b0);
        run_rand(22);
        step(1'b0, 1'b1, pk3(7, 7, 7), pk3(3, 3, 3), 1'b1);
        run_rand(22);

        // 6: phase 9 with div 5 clamps to 4
        step(1'b1, 1'b1, pk3(5, 5, 5), pk3(9, 9, 9), 1'b0);
        run_rand(40);

        // Random reconfigurations, including max ratio
        step(1'b1, 1'b1, pk3(15, 15, 15), pk3(14, 0, 15), 1'b1);
        run_rand(50);
        for (int r = 0; r < 8; r++) begin
            step(1'b1, 1'b1, VW'($urandom), VW'($urandom), 1'($urandom_range(0, 1)));
            run_rand(int'($urandom_range(5, 45)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
